// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises an async active-low reset, holds every domain in reset for a
// programmable period, then releases NUM_RST domain resets one by one; a software request re-runs it.
module rst_seq_ctrl #(
    parameter int NUM_RST        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               aclk_i,
    input  logic               areset_n_i,
    input  logic               sw_rst_req_i,
    output logic               aclk_o,
    output logic [NUM_RST-1:0] areset_n_o,
    output logic               rst_done_o,
    output logic [1:0]         rst_state_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_RST + 1);
    localparam int SYNC_W  = SYNC_STAGES - 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_RST - 1);
    localparam bit               ALL_AT_ONCE = (STAGGER_CYCLES == 0) || (NUM_RST == 1);

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // The state register doubles as the last synchroniser stage, so HOLD begins on the
    // same edge the synchronised reset would rise (edge SYNC_STAGES).
    logic [SYNC_W-1:0] sync;
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [NUM_RST-1:0] rel, rel_d;
    logic              done, done_d;

    always_ff @(posedge aclk_i or negedge areset_n_i) begin
        if (!areset_n_i) begin
            sync  <= '0;
            state <= ST_SYNC;
            cnt   <= '0;
            idx   <= '0;
            rel   <= '0;
            done  <= 1'b0;
        end else begin
            sync  <= (sync << 1) | SYNC_W'(1);
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            rel   <= rel_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rel_d   = rel;
        done_d  = done;
        case (state)
            ST_SYNC: begin
                if (sync[SYNC_W-1]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (sw_rst_req_i) begin
                    cnt_d = '0;
                    idx_d = '0;
                end else if (cnt == HOLD_LAST) begin
                    cnt_d = '0;
                    if (ALL_AT_ONCE) begin
                        rel_d   = '1;
                        done_d  = 1'b1;
                        idx_d   = IDX_W'(NUM_RST);
                        state_d = ST_DONE;
                    end else begin
                        rel_d   = NUM_RST'(1);
                        idx_d   = IDX_W'(1);
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rel_d   = '0;
                    done_d  = 1'b0;
                end else if (cnt == STAG_LAST) begin
                    // idx is the next channel to release; shifting keeps release thermometer-coded
                    cnt_d = '0;
                    rel_d = (rel << 1) | NUM_RST'(1);
                    idx_d = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                if (sw_rst_req_i) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rel_d   = '0;
                    done_d  = 1'b0;
                end
            end
        endcase
    end

    assign aclk_o      = aclk_i;
    assign areset_n_o  = rel;
    assign rst_done_o  = done;
    assign rst_state_o = state;

endmodule
